gray_result_decoder: RTL and testbench
======================================

# gray_result_decoder

Receive-side decoder for the Gray-coded result word produced by the 8-bit adder/subtractor block. It accepts one Gray-coded magnitude with its carry/sign flag and operation mode. It reconstructs the binary magnitude bit-serially, MSB first, and applies the sign/carry rule to produce a single two's-complement value. It sits downstream of the arithmetic unit, between a valid/ready producer and a valid/ready consumer.

## Interface
- `WIDTH`, default 8: Gray/magnitude width in bits (≥2).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: input word present.
- `in_ready` output 1: decoder can accept a word.
- `in_gray` input WIDTH: Gray-coded result magnitude.
- `in_carry` input 1: carry flag. In add mode this is the carry-out. In subtract mode, 1 means non-negative and 0 means negative.
- `in_mode` input 1: 0 = add, 1 = subtract.
- `out_valid` output 1: decoded value available.
- `out_ready` input 1: consumer accepts value.
- `out_value` output WIDTH+2: signed two's-complement result.
- `out_err` output 1: set with `out_valid` for a negative-zero input.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, DECODE, FIXUP, HOLD.
- **IDLE:** `in_ready`=1. When `in_valid`=1, latch `in_gray`, `in_carry` and `in_mode`, clear the binary accumulator and bit index, then go to DECODE.
- **DECODE:** one bit per cycle, MSB first: b[i] = b[i+1] XOR g[i], with b[WIDTH] treated as 0.
  - Index runs WIDTH-1 down to 0; after the bit-0 cycle, go to FIXUP.
  - The index never wraps; it is reloaded only in IDLE.
- **FIXUP:** one cycle, forms `out_value` from magnitude B (zero-extended):
  - mode 0: value = {0, carry, B}, range 0..2^(WIDTH+1)-1.
  - mode 1, carry 1: value = +B.
  - mode 1, carry 0: value = −B (two's complement, WIDTH+2 bits).
  - mode 1, carry 0, B = 0: value = 0 and `out_err`=1. This input is illegal because the upstream block never emits negative zero.
  - Then go to HOLD.
- **HOLD:** `out_valid`=1; `out_value` and `out_err` stay stable. On `out_ready`=1, go to IDLE.
- `in_valid` outside IDLE is ignored; the producer must hold its word until it sees `in_ready`.
- `in_ready` is a pure function of state; it has no combinational path from `out_ready`.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces, from any state including mid-DECODE or HOLD:
  - state = IDLE, `in_ready`=1, `out_valid`=0, `out_value`=0, `out_err`=0, `busy`=0.
  - All internal registers are cleared and the in-flight word is discarded.
- Latency: input accepted at edge 0 → DECODE for edges 1..WIDTH → FIXUP at edge WIDTH+1 → `out_valid` high after edge WIDTH+1. That is 9 cycles for WIDTH=8.
- Throughput: at best one word per WIDTH+3 cycles, since the HOLD→IDLE transition costs one cycle before the next accept.
- Backpressure: HOLD persists indefinitely while `out_ready`=0, with outputs unchanged.
- Simultaneous events: reset dominates every handshake. `out_ready` high outside HOLD has no effect.

## Structure
- Shared package `gray_dec_pkg`:
  - state enum {IDLE, DECODE, FIXUP, HOLD};
  - default-width constant `GD_WIDTH` = 8;
  - output-width function `out_w(w)` = w+2.
- Sub-module `gray_serial_stage`: holds the latched Gray word, the bit index and the XOR-chain accumulator. It exposes `start`, `step`, `done` and `mag[WIDTH-1:0]`.
- The top holds the FSM, handshakes and sign fixup.

## Test plan
- **Add with carry:** 200+100 gives `in_gray`=0x3A, carry=1, mode=0 → after 9 cycles `out_value`=300 (0x12C), `out_err`=0.
- **Negative subtract:** 5−9 gives `in_gray`=0x06, carry=0, mode=1 → `out_value`=−4 (0x3FC).
- **Non-negative subtract:** the same word with carry=1 → `out_value`=+4. Separately, `in_gray`=0x80, mode=0, carry=1 → 511 (0x1FF).
- **Backpressure:** `out_ready` held 0 for 5 cycles in HOLD → `out_valid`, `out_value` and `out_err` stable, `in_ready`=0. A new `in_valid` during that time is ignored.
- **Negative zero:** `in_gray`=0x00, mode=1, carry=0 → `out_value`=0, `out_err`=1.
- **Reset mid-operation:** `rst_n`=0 at DECODE cycle 4 → next cycle IDLE with all outputs zero and `in_ready`=1. A fresh word then decodes correctly with full latency.

Source files
------------

// File: rtl/gray_dec_pkg.sv
// gray_dec_pkg: shared types and width helpers for the Gray result decoder.
package gray_dec_pkg;
   typedef enum logic [1:0] {IDLE, DECODE, FIXUP, HOLD} gd_state_e;
   localparam int GD_WIDTH = 8;
   function automatic int out_w(input int w);
      return w + 2;
   endfunction
endpackage

// File: rtl/gray_result_decoder_if.sv
// gray_result_decoder_if: input/output valid-ready bundle of the Gray result decoder.
interface gray_result_decoder_if
   import gray_dec_pkg::*;
#(
   parameter int WIDTH = GD_WIDTH
);
   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           in_gray;
   logic                       in_carry;
   logic                       in_mode;
   logic                       out_valid;
   logic                       out_ready;
   logic [out_w(WIDTH)-1:0]    out_value;
   logic                       out_err;
   logic                       busy;
   modport slave (
      input  in_valid, in_gray, in_carry, in_mode, out_ready,
      output in_ready, out_valid, out_value, out_err, busy
   );
   modport master (
      output in_valid, in_gray, in_carry, in_mode, out_ready,
      input  in_ready, out_valid, out_value, out_err, busy
   );
endinterface

// File: rtl/gray_serial_stage.sv
// gray_serial_stage: bit-serial MSB-first Gray-to-binary XOR chain.
module gray_serial_stage
   import gray_dec_pkg::*;
#(
   parameter int WIDTH = GD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] gray_i,
   output logic             done_o,
   output logic [WIDTH-1:0] mag_o
);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   logic [WIDTH-1:0] gray_q, gray_d, acc_q, acc_d;
   logic [IW-1:0]    idx_q, idx_d;
   assign done_o = idx_q == '0;
   assign mag_o  = acc_q;
   // acc shifts left each step; acc_q[0] is always the previously decoded (higher) bit
   always_comb begin
      gray_d = start_i ? gray_i : gray_q;
      idx_d  = start_i ? IW'(WIDTH-1) : (step_i && !done_o) ? idx_q - IW'(1) : idx_q;
      acc_d  = start_i ? '0 : step_i ? {acc_q[WIDTH-2:0], acc_q[0] ^ gray_q[idx_q]} : acc_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gray_q <= '0;
         idx_q  <= '0;
         acc_q  <= '0;
      end else begin
         gray_q <= gray_d;
         idx_q  <= idx_d;
         acc_q  <= acc_d;
      end
   end
endmodule

// File: rtl/gray_result_decoder.sv
// gray_result_decoder: handshaked Gray result decoder with sign/carry fixup.
module gray_result_decoder
   import gray_dec_pkg::*;
#(
   parameter int WIDTH = GD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gray_result_decoder_if.slave  bus_io
);
   localparam int OW = out_w(WIDTH);
   gd_state_e        state_q, state_d;
   logic             carry_q, carry_d, mode_q, mode_d, err_q, err_d;
   logic [OW-1:0]    value_q, value_d, ext;
   logic             start, step, done;
   logic [WIDTH-1:0] mag;
   gray_serial_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .step_i  (step),
      .gray_i  (bus_io.in_gray),
      .done_o  (done),
      .mag_o   (mag)
   );
   assign ext              = {2'b00, mag};
   assign bus_io.in_ready  = state_q == IDLE;
   assign bus_io.out_valid = state_q == HOLD;
   assign bus_io.busy      = state_q != IDLE;
   assign bus_io.out_value = value_q;
   assign bus_io.out_err   = err_q;
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      step    = 1'b0;
      carry_d = carry_q;
      mode_d  = mode_q;
      value_d = value_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (bus_io.in_valid) begin
            start   = 1'b1;
            carry_d = bus_io.in_carry;
            mode_d  = bus_io.in_mode;
            state_d = DECODE;
         end
         DECODE: begin
            step    = 1'b1;
            state_d = done ? FIXUP : DECODE;
         end
         FIXUP: begin
            value_d = mode_q ? (carry_q ? ext : -ext) : {1'b0, carry_q, mag};
            err_d   = mode_q && !carry_q && mag == '0;
            state_d = HOLD;
         end
         HOLD: state_d = bus_io.out_ready ? IDLE : HOLD;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
         mode_q  <= 1'b0;
         value_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         mode_q  <= mode_d;
         value_q <= value_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_gray_result_decoder.sv
// tb_gray_result_decoder: directed-vector self-checking bench for gray_result_decoder.
module tb_gray_result_decoder;
   import gray_dec_pkg::*;
   localparam int W = GD_WIDTH;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   gray_result_decoder_if #(.WIDTH(W)) bus ();
   gray_result_decoder #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] g, input logic c, input logic m);
      int k = 0;
      bus.in_gray  = g;
      bus.in_carry = c;
      bus.in_mode  = m;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && k < 50) begin
         tick();
         k++;
      end
      check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int cyc = 0;
      while (!bus.out_valid && cyc < 30) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, cyc, W + 1);
   endtask

   task automatic release_out(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   task automatic run(input string tag, input logic [W-1:0] g, input logic c, input logic m,
                      input logic [31:0] ev, input logic ee);
      send(g, c, m);
      wait_out(tag);
      check({tag, "_value"}, {22'd0, bus.out_value}, ev);
      check({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, ee});
      check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      release_out(tag);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_gray   = '0;
      bus.in_carry  = 1'b0;
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_value", {22'd0, bus.out_value}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst_n = 1'b1;
      tick();
      run("add300", 8'h3A, 1'b1, 1'b0, 32'h12C, 1'b0);
      run("sub_neg4", 8'h06, 1'b0, 1'b1, 32'h3FC, 1'b0);
      run("sub_pos4", 8'h06, 1'b1, 1'b1, 32'h004, 1'b0);
      run("add511", 8'h80, 1'b1, 1'b0, 32'h1FF, 1'b0);
      run("neg_zero", 8'h00, 1'b0, 1'b1, 32'h000, 1'b1);
      run("add_zero", 8'h00, 1'b0, 1'b0, 32'h000, 1'b0);
      run("sub_neg255", 8'h80, 1'b0, 1'b1, 32'h301, 1'b0);
      run("sub_pos1", 8'h01, 1'b1, 1'b1, 32'h001, 1'b0);
      // Backpressure: a competing word offered during HOLD must be ignored
      send(8'h3A, 1'b1, 1'b0);
      wait_out("bp");
      bus.in_gray  = 8'h06;
      bus.in_carry = 1'b0;
      bus.in_mode  = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_value", {22'd0, bus.out_value}, 32'h12C);
         check("bp_err", {31'd0, bus.out_err}, 32'd0);
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid = 1'b0;
      release_out("bp");
      run("post_bp", 8'h06, 1'b0, 1'b1, 32'h3FC, 1'b0);
      // Reset during the fourth DECODE cycle
      send(8'h80, 1'b1, 1'b0);
      repeat (3) tick();
      check("mid_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mrst_value", {22'd0, bus.out_value}, 32'd0);
      check("mrst_err", {31'd0, bus.out_err}, 32'd0);
      check("mrst_busy", {31'd0, bus.busy}, 32'd0);
      run("post_rst", 8'h3A, 1'b1, 1'b0, 32'h12C, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
